io_responder: RTL
=================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, CPU memory-bus address width; SHALL be >= 4.
REQ-002 Parameter DATA_WIDTH, default 16, CPU memory-bus data width; SHALL be >= 8.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 we  input  1  CPU write enable (the CPU mem_we).
REQ-006 addr  input  ADDR_WIDTH  CPU word address (the CPU mem_addr).
REQ-007 data  input  DATA_WIDTH  CPU write data (the CPU mem_data).
REQ-008 out  output  DATA_WIDTH  registered read data returned to the CPU.
REQ-009 sel  output  1  registered: out holds IO data this cycle; top muxes out over memory out.
REQ-010 in_port  input  DATA_WIDTH  asynchronous external input.
REQ-011 out_port  output  DATA_WIDTH  external output, equals OUT register.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 IO window = top 8 words: hit when addr[ADDR_WIDTH-1:3] all ones; offset = addr[2:0].
REQ-014 Register map: 0 OUT rw; 1 IN ro; 2 CNT rw; 3 CMP rw; 4 CTRL rw (bit0 EN, bit1 RELOAD, bit2 IE, others read 0); 5 STATUS (bit0 MATCH, bit1 INCHG, W1C, others read 0); 6 PRESC rw; 7 SCRATCH rw.
REQ-015 Write: on rising edge with we=1 and hit, register at offset takes data; writes to IN ignored; writes outside window ignored.
REQ-016 Read latency 1 cycle: every edge, out <= hit ? reg[offset] (pre-write value if we=1) : 0; sel <= hit.
REQ-017 IN = in_port through a 2-flop synchronizer; IN updates from 2nd stage; INCHG set on any edge where 2nd stage value differs from IN.
REQ-018 Prescaler pc: when EN=0, pc <= 0, no ticks; when EN=1, tick when pc == PRESC then pc <= 0, else pc <= pc+1; tick period PRESC+1 cycles.
REQ-019 On tick: if CNT == CMP, MATCH set and CNT <= RELOAD ? 0 : CNT+1; else CNT <= CNT+1; CNT wraps all-ones -> 0 with no flag.
REQ-020 CPU write to CNT same edge as tick: write wins, tick's increment discarded, MATCH still evaluated on pre-edge CNT.
REQ-021 CPU write to PRESC takes effect next cycle; pc not cleared.
REQ-022 STATUS W1C: writing 1 clears bit; set event and clear on same edge -> bit stays 1.
REQ-023 irq = IE & (MATCH | INCHG), combinational from registers, glitch-free (registered inputs only).
REQ-024 out_port = OUT register directly.

Reset
REQ-025 rst_n=0 asynchronously clears OUT, CNT, CMP, CTRL, STATUS, PRESC, SCRATCH, pc, synchronizer, IN, out, sel; so out_port=0, irq=0, out=0, sel=0.
REQ-026 Reset asserted mid-count aborts counting; after release counter stays 0 and disabled until CTRL written.
REQ-027 First edge after rst_n rises performs normal operation; no extra wait cycles.

Verification
REQ-028 Write 0xA5A5 to addr 0x38, then read 0x38 -> out_port=0xA5A5 same cycle after write edge; out=0xA5A5, sel=1 one cycle after read address.
REQ-029 Read addr 0x01 (outside window) after writing 0x1234 to 0x01 -> out=0, sel=0, no IO register changed.
REQ-030 PRESC=3, CMP=5, CTRL=0b111 -> CNT increments every 4 cycles, MATCH and irq=1 at tick where CNT==5, CNT returns to 0; write 0x0001 to 0x3D -> MATCH=0, irq=0.
REQ-031 in_port changes 0x0000->0x0009 -> IN reads 0x0009 no earlier than 2 edges later; INCHG=1; with IE=1 irq=1.
REQ-032 CNT=0xFFFF, CMP=0x0010, RELOAD=0, PRESC=0, EN=1 -> next tick CNT=0x0000, MATCH stays 0.
REQ-033 Write CNT=0x0100 on a tick edge with CNT==CMP -> CNT=0x0100, MATCH=1; rst_n pulse mid-count -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO block in the top eight words of the CPU
// address space. It holds an output latch, a synchronized input, a
// prescaled compare counter and a sticky status register, and raises a level
// interrupt from the status register.
module io_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  sel,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] OFF_OUT     = 3'd0;
  localparam logic [2:0] OFF_IN      = 3'd1;
  localparam logic [2:0] OFF_CNT     = 3'd2;
  localparam logic [2:0] OFF_CMP     = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;
  localparam logic [2:0] OFF_PRESC   = 3'd6;
  localparam logic [2:0] OFF_SCRATCH = 3'd7;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic                  hit;
  logic [2:0]            offset;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] in_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cmp_q;
  logic [2:0]            ctrl_q;
  logic [1:0]            status_q;
  logic [DATA_WIDTH-1:0] presc_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] sync_p0;
  logic [DATA_WIDTH-1:0] sync_p1;

  logic                  ctrl_en;
  logic                  ctrl_reload;
  logic                  ctrl_ie;
  logic                  tick;
  logic                  match_set;
  logic                  inchg_set;
  logic [DATA_WIDTH-1:0] rdata;

  assign hit    = &addr[ADDR_WIDTH-1:3];
  assign offset = addr[2:0];
  assign wr_en  = we & hit;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_reload = ctrl_q[1];
  assign ctrl_ie     = ctrl_q[2];

  // A tick compares against the pre-edge PRESC, so a PRESC write only
  // influences the following cycle and never clears pc.
  assign tick      = ctrl_en && (pc_q == presc_q);
  assign match_set = tick && (cnt_q == cmp_q);
  assign inchg_set = (sync_p1 != in_q);

  assign out_port = out_q;
  // Built only from flops, so the request line cannot glitch on bus activity.
  assign irq      = ctrl_ie & (status_q[0] | status_q[1]);

  // Two-flop synchronizer on in_port, then the architectural IN register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      in_q    <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
      in_q    <= sync_p1;
    end
  end

  // Prescaler: free-runs while enabled, restarts at zero on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (!ctrl_en) begin
      pc_q <= '0;
    end else if (tick) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + ONE;
    end
  end

  // Counter: a CPU write overrides a same-edge tick; wrap to zero is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (wr_en && offset == OFF_CNT) begin
      cnt_q <= data;
    end else if (tick) begin
      if (match_set && ctrl_reload) cnt_q <= '0;
      else                          cnt_q <= cnt_q + ONE;
    end
  end

  // Plain read/write configuration and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      cmp_q     <= '0;
      ctrl_q    <= '0;
      presc_q   <= '0;
      scratch_q <= '0;
    end else if (wr_en) begin
      case (offset)
        OFF_OUT:     out_q     <= data;
        OFF_CMP:     cmp_q     <= data;
        OFF_CTRL:    ctrl_q    <= data[2:0];
        OFF_PRESC:   presc_q   <= data;
        OFF_SCRATCH: scratch_q <= data;
        default:     ;
      endcase
    end
  end

  // Sticky status bits: a set event on the same edge beats a W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q[0] <= match_set |
                     (status_q[0] & ~(wr_en && offset == OFF_STATUS && data[0]));
      status_q[1] <= inchg_set |
                     (status_q[1] & ~(wr_en && offset == OFF_STATUS && data[1]));
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_OUT:     rdata = out_q;
      OFF_IN:      rdata = in_q;
      OFF_CNT:     rdata = cnt_q;
      OFF_CMP:     rdata = cmp_q;
      OFF_CTRL:    rdata = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
      OFF_STATUS:  rdata = {{(DATA_WIDTH-2){1'b0}}, status_q};
      OFF_PRESC:   rdata = presc_q;
      OFF_SCRATCH: rdata = scratch_q;
      default:     rdata = '0;
    endcase
  end

  // Registered read port; sel tells the CPU-side mux to take IO data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      sel <= 1'b0;
    end else begin
      out <= hit ? rdata : '0;
      sel <= hit;
    end
  end

endmodule
